// File: rtl/bcd_display_sequencer_if.sv
// Handshake bundle for bcd_display_sequencer: binary value in, ASCII digit stream out.
// The slave modport is the sequencer side; the master modport is the producer/sink side.
interface bcd_display_sequencer_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_char;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_char, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_char, out_last, busy
  );
endinterface

// File: rtl/bcd_display_sequencer.sv
// Bit-serial double-dabble binary-to-ASCII formatter, streams digits MSD first.
// Optional macro BCD_SEQ_NEWLINE_EN appends CR/LF after the last digit.
module bcd_display_sequencer #(
  parameter int N          = 16,
  parameter int NUM_DIGITS = 5
) (
  input logic                   clk,
  input logic                   reset,
  bcd_display_sequencer_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 4 * NUM_DIGITS;

`ifdef BCD_SEQ_NEWLINE_EN
  typedef enum logic [2:0] {IDLE, CONVERT, EMIT, CR, LF} state_t;
`else
  typedef enum logic [2:0] {IDLE, CONVERT, EMIT} state_t;
`endif

  state_t          state_reg, state_next;
  logic [N-1:0]    bin_reg, bin_next;
  logic [BW-1:0]   bcd_reg, bcd_next, bcd_adj;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [DW-1:0]   digit_reg, digit_next;
  logic            seen_reg, seen_next;
  logic            zero_reg, zero_next;
  logic [3:0]      digit_val [NUM_DIGITS];
  logic [3:0]      cur_digit;

  logic            in_ready, busy, out_valid, out_last;
  logic [7:0]      out_char;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      // Nibble stays within 4 bits: max input 9 becomes 12 before the shift.
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      assign digit_val[gi] = bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign cur_digit = digit_val[digit_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      digit_reg <= '0;
      seen_reg  <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      digit_reg <= digit_next;
      seen_reg  <= seen_next;
      zero_reg  <= zero_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    digit_next = digit_reg;
    seen_next  = seen_reg;
    zero_next  = zero_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    out_char   = 8'h00;
    out_last   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) begin
          bin_next   = bus.in_data;
          bcd_next   = '0;
          cnt_next   = '0;
          zero_next  = (bus.in_data == '0);
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(N - 1)) begin
          state_next = EMIT;
          digit_next = DW'(NUM_DIGITS - 1);
          seen_next  = 1'b0;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (zero_reg)
          out_char = 8'h30;
        else if (!seen_reg && cur_digit == 4'd0)
          out_char = 8'h5F;
        else
          out_char = 8'h30 + {4'h0, cur_digit};
`ifndef BCD_SEQ_NEWLINE_EN
        out_last = (digit_reg == '0);
`endif
        if (bus.out_ready) begin
          if (cur_digit != 4'd0)
            seen_next = 1'b1;
          if (digit_reg == '0) begin
`ifdef BCD_SEQ_NEWLINE_EN
            state_next = CR;
`else
            state_next = IDLE;
`endif
          end else begin
            digit_next = digit_reg - 1'b1;
          end
        end
      end
`ifdef BCD_SEQ_NEWLINE_EN
      CR: begin
        out_valid = 1'b1;
        out_char  = 8'h0D;
        if (bus.out_ready)
          state_next = LF;
      end
      LF: begin
        out_valid = 1'b1;
        out_char  = 8'h0A;
        out_last  = 1'b1;
        if (bus.out_ready)
          state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_char  = out_char;
  assign bus.out_last  = out_last;
endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Directed self-checking bench for bcd_display_sequencer (default N=16, 5 digits).
// Honours BCD_SEQ_NEWLINE_EN by expecting the trailing CR/LF bytes.
module tb_bcd_display_sequencer;
  localparam int N = 16;
`ifdef BCD_SEQ_NEWLINE_EN
  localparam int NB = 7;
`else
  localparam int NB = 5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_display_sequencer_if #(.N(N)) bus ();

  bcd_display_sequencer #(.N(N), .NUM_DIGITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] exp_chars [NB];
  logic [7:0] got_chars [NB];
  logic       got_last  [NB];
  bit         got_ok, got_stable, got_nobubble, got_leak;

  task automatic set_exp(input logic [7:0] b0, b1, b2, b3, b4);
    exp_chars[0] = b0; exp_chars[1] = b1; exp_chars[2] = b2;
    exp_chars[3] = b3; exp_chars[4] = b4;
`ifdef BCD_SEQ_NEWLINE_EN
    exp_chars[5] = 8'h0D; exp_chars[6] = 8'h0A;
`endif
  endtask

  // Hand a value over at a negedge; returns at the negedge after the accept edge.
  task automatic send_value(input logic [N-1:0] v);
    int w = 0;
    while (!bus.in_ready && w < 200) begin @(negedge clk); w++; end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Gathers NB bytes with optional stalls; returns at the negedge after the final transfer.
  task automatic collect(input int stall, input bit inject, input int value);
    string s;
    got_ok = 1; got_stable = 1; got_nobubble = 1; got_leak = 0;
    s = "";
    for (int i = 0; i < NB; i++) begin
      int w = 0;
      while (!bus.out_valid && w < 200) begin @(negedge clk); w++; end
      if (!bus.out_valid) begin got_ok = 0; return; end
      if (i > 0 && w > 0) got_nobubble = 0;
      got_chars[i] = bus.out_char;
      got_last[i]  = bus.out_last;
      for (int k = 0; k < stall; k++) begin
        bus.out_ready = 1'b0;
        if (inject) begin bus.in_valid = 1'b1; bus.in_data = 16'd5; end
        @(negedge clk);
        if (bus.out_char !== got_chars[i] || bus.out_valid !== 1'b1 ||
            bus.out_last !== got_last[i]) got_stable = 0;
        if (inject && bus.in_ready !== 1'b0) got_leak = 1;
      end
      if (inject) bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      s = {s, $sformatf(" %02h%s", got_chars[i], got_last[i] ? "*" : "")};
    end
    $display("number %0d ->%s", value, s);
  endtask

  task automatic test_reset;
    compared++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.out_char !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_state: got rdy=%b busy=%b vld=%b last=%b char=%h, want 1 0 0 0 00",
               bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.out_char);
    end
  endtask

  task automatic test_basic;
    int lat = 0;
    send_value(16'd1234);
    while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
    compared++;
    if (lat !== 16) begin
      mismatched++;
      $display("FAIL latency_1234: got %0d cycles, want 16", lat);
    end
    set_exp(8'h5F, 8'h31, 8'h32, 8'h33, 8'h34);
    collect(0, 0, 1234);
    compared++;
    if (!got_ok || !got_nobubble) begin
      mismatched++;
      $display("FAIL stream_1234: ok=%b nobubble=%b, want 1 1", got_ok, got_nobubble);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got_chars[i] !== exp_chars[i] || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL byte_1234[%0d]: got %h last=%b, want %h last=%b",
                 i, got_chars[i], got_last[i], exp_chars[i], (i == NB - 1));
      end
    end
    compared++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_1234: got rdy=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_value(input logic [N-1:0] v, input logic [7:0] b0, b1, b2, b3, b4);
    send_value(v);
    set_exp(b0, b1, b2, b3, b4);
    collect(0, 0, int'(v));
    compared++;
    if (!got_ok) begin
      mismatched++;
      $display("FAIL stream_%0d: timeout, got ok=0 want 1", v);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got_chars[i] !== exp_chars[i] || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL byte_%0d[%0d]: got %h last=%b, want %h last=%b",
                 v, i, got_chars[i], got_last[i], exp_chars[i], (i == NB - 1));
      end
    end
  endtask

  task automatic test_backpressure;
    send_value(16'd907);
    set_exp(8'h5F, 8'h5F, 8'h39, 8'h30, 8'h37);
    collect(3, 1, 907);
    compared++;
    if (!got_ok || !got_stable || got_leak) begin
      mismatched++;
      $display("FAIL backpressure_907: ok=%b stable=%b rdy_leak=%b, want 1 1 0",
               got_ok, got_stable, got_leak);
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got_chars[i] !== exp_chars[i] || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL byte_907[%0d]: got %h last=%b, want %h last=%b",
                 i, got_chars[i], got_last[i], exp_chars[i], (i == NB - 1));
      end
    end
    @(negedge clk);
    compared++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL no_stray_accept: got busy=%b vld=%b, want 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int w = 0;
    bit extra = 0;
    send_value(16'd4321);
    for (int i = 0; i < 2; i++) begin
      while (!bus.out_valid && w < 200) begin @(negedge clk); w++; end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h33) begin
      mismatched++;
      $display("FAIL third_byte_4321: got vld=%b char=%h, want 1 33", bus.out_valid, bus.out_char);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_char !== 8'h00) begin
      mismatched++;
      $display("FAIL async_reset: got vld=%b rdy=%b busy=%b char=%h, want 0 1 0 00",
               bus.out_valid, bus.in_ready, bus.busy, bus.out_char);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) extra = 1;
    end
    bus.out_ready = 1'b0;
    compared++;
    if (extra) begin
      mismatched++;
      $display("FAIL post_reset_quiet: got out_valid=1 after reset, want 0");
    end
    $display("number 4321 -> aborted by reset");
    test_value(16'd42, 8'h5F, 8'h5F, 8'h5F, 8'h34, 8'h32);
  endtask

  task automatic test_back_to_back;
    send_value(16'd1234);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd58;
    set_exp(8'h5F, 8'h31, 8'h32, 8'h33, 8'h34);
    collect(0, 0, 1234);
    compared++;
    if (!got_ok || got_chars[4] !== 8'h34 || got_chars[0] !== 8'h5F) begin
      mismatched++;
      $display("FAIL b2b_first: got ok=%b c0=%h c4=%h, want 1 5f 34", got_ok, got_chars[0], got_chars[4]);
    end
    compared++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_idle: got rdy=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    compared++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_accept: got busy=%b rdy=%b, want 1 0", bus.busy, bus.in_ready);
    end
    set_exp(8'h5F, 8'h5F, 8'h5F, 8'h35, 8'h38);
    collect(0, 0, 58);
    compared++;
    if (!got_ok) begin
      mismatched++;
      $display("FAIL b2b_second: timeout, got ok=0 want 1");
    end
    for (int i = 0; i < NB; i++) begin
      compared++;
      if (got_chars[i] !== exp_chars[i] || got_last[i] !== (i == NB - 1)) begin
        mismatched++;
        $display("FAIL byte_58[%0d]: got %h last=%b, want %h last=%b",
                 i, got_chars[i], got_last[i], exp_chars[i], (i == NB - 1));
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_value(16'd0,     8'h30, 8'h30, 8'h30, 8'h30, 8'h30);
    test_value(16'd65535, 8'h36, 8'h35, 8'h35, 8'h33, 8'h35);
    test_value(16'd1,     8'h5F, 8'h5F, 8'h5F, 8'h5F, 8'h31);
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
